// File: rtl/wb_select_ctrl.sv
// rtl/wb_select_ctrl.sv - writeback select sequencer for the 8:1 one-hot result mux
// Waits on long-latency units, then issues a one-cycle one-hot select with write enable.
module wb_select_ctrl #(
    parameter logic [7:0] LONG_MASK = 8'b0010_0000,
    parameter int         TIMEOUT   = 16,
    parameter int         CW        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [2:0] req_src,
    output logic       req_ready,
    input  logic [7:0] unit_done,
    output logic [7:0] sel,
    output logic       wr_en,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_WRITE,
        S_ABORT
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state, state_d;
    logic [2:0]    src_q, src_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [7:0]    sel_d;
    logic          wr_en_d;
    logic          timeout_err_d;

    // Outputs are computed for the state being entered so they are registered
    // and line up with the WRITE/ABORT cycle itself.
    always_comb begin
        state_d       = state;
        src_d         = src_q;
        cnt_d         = cnt;
        sel_d         = 8'h00;
        wr_en_d       = 1'b0;
        timeout_err_d = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    src_d = req_src;
                    if (LONG_MASK[req_src]) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_WRITE;
                        sel_d   = 8'(1) << req_src;
                        wr_en_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // Done takes priority over an expiring counter.
                if (unit_done[src_q]) begin
                    state_d = S_WRITE;
                    sel_d   = 8'(1) << src_q;
                    wr_en_d = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_d       = S_ABORT;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_WRITE: state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            src_q       <= 3'd0;
            cnt         <= '0;
            sel         <= 8'h00;
            wr_en       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            src_q       <= src_d;
            cnt         <= cnt_d;
            sel         <= sel_d;
            wr_en       <= wr_en_d;
            timeout_err <= timeout_err_d;
        end
    end

    assign req_ready = (state == S_IDLE);
    assign busy      = (state == S_WAIT) || (state == S_WRITE);

endmodule

// File: tb/tb_wb_select_ctrl.sv
// tb/tb_wb_select_ctrl.sv - self-checking bench for wb_select_ctrl
// Transaction-level model plus directed scenarios and randomized traffic.
module tb_wb_select_ctrl;

    localparam logic [7:0] LONG_MASK = 8'b0010_0000;
    localparam int         TIMEOUT   = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [2:0] req_src;
    logic       req_ready;
    logic [7:0] unit_done;
    logic [7:0] sel;
    logic       wr_en;
    logic       busy;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    wb_select_ctrl #(.LONG_MASK(LONG_MASK), .TIMEOUT(TIMEOUT), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_src(req_src),
        .req_ready(req_ready), .unit_done(unit_done), .sel(sel), .wr_en(wr_en),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a request is either absent, pending on a unit (with a count of
    // elapsed wait cycles), or being written/aborted in the current cycle.
    bit       m_ok = 0;
    bit       m_waiting, m_write, m_abort;
    int       m_waited;
    int       m_src;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ok = 1; m_waiting = 0; m_write = 0; m_abort = 0; m_waited = 0; m_src = 0;
        end else if (m_ok) begin
            if (m_write || m_abort) begin
                m_write = 0;
                m_abort = 0;
            end else if (m_waiting) begin
                if (unit_done[m_src]) begin
                    m_waiting = 0; m_write = 1;
                end else if (m_waited == TIMEOUT - 1) begin
                    m_waiting = 0; m_abort = 1;
                end else begin
                    m_waited++;
                end
            end else if (req_valid) begin
                m_src = int'(req_src);
                if (LONG_MASK[req_src]) begin
                    m_waiting = 1; m_waited = 0;
                end else begin
                    m_write = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("sel", 32'(sel), m_write ? (32'd1 << m_src) : 32'd0);
            chk("wr_en", 32'(wr_en), 32'(m_write));
            chk("timeout_err", 32'(timeout_err), 32'(m_abort));
            chk("busy", 32'(busy), 32'(m_waiting | m_write));
            chk("req_ready", 32'(req_ready), 32'(!(m_waiting | m_write | m_abort)));
            chk("sel_onehot0", 32'($onehot0(sel)), 32'd1);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    int  n;
    bit  seen;

    initial begin
        rst_n = 1'b0; req_valid = 1'b1; req_src = 3'd3; unit_done = 8'h00;
        // Reset with a request pending
        repeat (3) step();
        rst_n = 1'b1; req_valid = 1'b0;
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_wr_en", 32'(wr_en), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h1);
        step();

        // Short source 3
        req_valid = 1'b1; req_src = 3'd3;
        step();
        req_valid = 1'b0;
        chk("short_sel", 32'(sel), 32'h08);
        chk("short_wr_en", 32'(wr_en), 32'h1);
        chk("short_ready", 32'(req_ready), 32'h0);
        step();
        chk("short_sel_after", 32'(sel), 32'h0);
        chk("short_ready_after", 32'(req_ready), 32'h1);

        // Long source 5, done sampled on the 4th edge after accept
        req_valid = 1'b1; req_src = 3'd5;
        step();
        req_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            n += int'(busy);
            step();
        end
        n += int'(busy);
        unit_done = 8'h20;
        step();
        unit_done = 8'h00;
        n += int'(busy);
        chk("long_sel", 32'(sel), 32'h20);
        chk("long_wr_en", 32'(wr_en), 32'h1);
        step();
        n += int'(busy);
        chk("long_busy_cycles", 32'(n), 32'd5);

        // Timeout on source 5
        req_valid = 1'b1; req_src = 3'd5;
        step();
        req_valid = 1'b0;
        n = 0; seen = 0;
        while (busy && n < 100) begin
            n++;
            seen |= wr_en;
            step();
        end
        chk("to_wait_cycles", 32'(n), 32'd16);
        chk("to_err", 32'(timeout_err), 32'h1);
        chk("to_no_write", 32'(seen | wr_en), 32'h0);
        step();
        chk("to_err_pulse", 32'(timeout_err), 32'h0);

        // Wrong done held, correct done at the timeout edge
        unit_done = 8'h01;
        req_valid = 1'b1; req_src = 3'd5;
        step();
        req_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            seen |= wr_en | timeout_err;
            step();
        end
        chk("wrong_done_ignored", 32'(seen), 32'h0);
        unit_done = 8'h21;
        step();
        unit_done = 8'h00;
        chk("edge_done_wr", 32'(wr_en), 32'h1);
        chk("edge_done_sel", 32'(sel), 32'h20);
        chk("edge_done_noerr", 32'(timeout_err), 32'h0);
        step();

        // Reset in the middle of a wait
        req_valid = 1'b1; req_src = 3'd5;
        step();
        req_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_ready", 32'(req_ready), 32'h1);
        chk("midrst_sel", 32'(sel), 32'h0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            seen |= wr_en | timeout_err;
        end
        chk("midrst_silent", 32'(seen), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            req_valid = ($urandom_range(0, 2) != 0);
            req_src   = ($urandom_range(0, 2) == 0) ? 3'd5 : 3'($urandom);
            unit_done = 8'($urandom) & 8'($urandom) & 8'($urandom);
            step();
        end
        rst_n = 1'b1; req_valid = 1'b0; unit_done = 8'h00;
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
